// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES decryption, one Feistel round per clock, subkeys K16..K1 by right rotation; DES_DECRYPT_KEY_PARITY_CHECK_EN adds key parity checking.
// Latency: o_valid rises 16 cycles after acceptance; minimum initiation interval 18 cycles.
// Backpressure: o_ready low while busy; result held in DONE with stable outputs until i_ready.
module des_decrypt_core (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_ciphertext,
  input  logic [63:0] i_key,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_plaintext,
  output logic        o_key_err
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Permutation tables: entry i (FIPS numbering) lives in byte i counted from the MSB.
  localparam logic [511:0] IP_T = {
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,  8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,  8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};
  localparam logic [511:0] FP_T = {
    8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,  8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
    8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,  8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
    8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,  8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
    8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,  8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};
  localparam logic [447:0] PC1_T = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4};
  localparam logic [383:0] PC2_T = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32};
  localparam logic [383:0] E_T = {
    8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
    8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
    8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1};
  localparam logic [255:0] P_T = {
    8'd16, 8'd7, 8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17, 8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
    8'd2,  8'd8, 8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,  8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25};
  // Shared S-box array: 64 nibbles per box, row-major, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm64(input logic [63:0] x, input logic [511:0] t);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64 - int'(t[8*(63-i) +: 8])];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64 - int'(PC1_T[8*(55-i) +: 8])];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56 - int'(PC2_T[8*(47-i) +: 8])];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] rin, input logic [47:0] k);
    logic [47:0] e_be, x_le;
    logic [31:0] s_le, s_be, y;
    logic [5:0]  six, sel;
    logic [3:0]  nib;
    for (int i = 0; i < 48; i++) e_be[47-i] = rin[32 - int'(E_T[8*(47-i) +: 8])];
    e_be = e_be ^ k;
    for (int i = 0; i < 48; i++) x_le[i] = e_be[47-i];
    for (int b = 0; b < 8; b++) begin
      six = x_le[6*b +: 6];
      // Row from the outer bits (FIPS b1,b6), column from the inner four.
      sel = {six[0], six[5], six[1], six[2], six[3], six[4]};
      nib = SBOX[b][255 - 4*int'(sel) -: 4];
      for (int j = 0; j < 4; j++) s_le[4*b+j] = nib[3-j];
    end
    for (int i = 0; i < 32; i++) s_be[i] = s_le[31-i];
    for (int i = 0; i < 32; i++) y[31-i] = s_be[32 - int'(P_T[8*(31-i) +: 8])];
    return y;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] l, r, r_nxt;
  logic [27:0] c, d, c_rot, d_rot;
  logic [3:0]  n;
  logic [63:0] plaintext;
  logic        rot_one;

  // Undo the encryption shift of round 17-n; single shifts belong to rounds 16, 9 and 2.
  assign rot_one = (n == 4'd1) || (n == 4'd8) || (n == 4'd15);
  assign c_rot   = (n == 4'd0) ? c : rot_one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
  assign d_rot   = (n == 4'd0) ? d : rot_one ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
  assign r_nxt   = l ^ feistel(r, pc2({c_rot, d_rot}));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)     state_nxt = ROUND;
      ROUND:   if (n == 4'd15)  state_nxt = DONE;
      DONE:    if (i_ready)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      l <= '0;
      r <= '0;
      c <= '0;
      d <= '0;
      n <= '0;
      plaintext <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          {l, r} <= perm64(i_ciphertext, IP_T);
          {c, d} <= pc1(i_key);
          n <= 4'd0;
        end
        ROUND: begin
          l <= r;
          r <= r_nxt;
          c <= c_rot;
          d <= d_rot;
          n <= n + 4'd1;
          if (n == 4'd15) plaintext <= perm64({r_nxt, r}, FP_T);
        end
        default: ;
      endcase
    end
  end

`ifdef DES_DECRYPT_KEY_PARITY_CHECK_EN
  logic       key_err;
  logic [7:0] byte_odd;
  always_comb begin
    byte_odd = '0;
    for (int b = 0; b < 8; b++) byte_odd[b] = ^i_key[8*b +: 8];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst)                           key_err <= 1'b0;
    else if (state == IDLE && i_valid)   key_err <= ~&byte_odd;
  end
  assign o_key_err = key_err;
`else
  assign o_key_err = 1'b0;
`endif

  assign o_ready     = (state == IDLE);
  assign o_valid     = (state == DONE);
  assign o_plaintext = plaintext;
endmodule

// File: tb/tb_des_decrypt_core.sv
// Bench for des_decrypt_core: known-answer table, handshake corner sequences, and random round-trips
// through a textbook DES model (stored subkey list, left-shift schedule) kept inside the bench.
module tb_des_decrypt_core;
  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_ready;
  logic [63:0] i_ciphertext, i_key;
  logic        o_ready, o_valid, o_key_err;
  logic [63:0] o_plaintext;
  int checks = 0;
  int errors = 0;

`ifdef DES_DECRYPT_KEY_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  des_decrypt_core dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ciphertext(i_ciphertext), .i_key(i_key), .o_valid(o_valid), .i_ready(i_ready),
    .o_plaintext(o_plaintext), .o_key_err(o_key_err)
  );

  int ip_t[$] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                  57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int e_t[$] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t[$] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int shifts[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int fp_t[$];
  logic [255:0] sbox_t [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Output bit i (FIPS numbering) takes input bit t[i]; result right-aligned.
  function automatic logic [63:0] pm(input logic [63:0] x, input int inw, input int t[$]);
    logic [63:0] y;
    y = '0;
    foreach (t[i]) y = {y[62:0], x[inw - t[i]]};
    return y;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] rr, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  six;
    int row, col;
    t = pm({32'h0, rr}, 32, e_t);
    x = t[47:0] ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47 - 6*b -: 6];
      row = 2 * six[5] + six[0];
      col = int'(six[4:1]);
      s = {s[27:0], sbox_t[b][255 - 4*(16*row + col) -: 4]};
    end
    t = pm({32'h0, s}, 32, p_t);
    return t[31:0];
  endfunction

  function automatic logic [63:0] ref_des(input logic [63:0] blk, input logic [63:0] key, input bit dec);
    logic [47:0] ks[16];
    logic [63:0] t;
    logic [27:0] c, d;
    logic [31:0] l, r, tmp;
    t = pm(key, 64, pc1_t);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < shifts[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = pm({8'h0, c, d}, 56, pc2_t);
      ks[i] = t[47:0];
    end
    t = pm(blk, 64, ip_t);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      tmp = r;
      r = l ^ ref_f(r, dec ? ks[15-i] : ks[i]);
      l = tmp;
    end
    return pm({r, l}, 64, fp_t);
  endfunction

  function automatic logic ref_par_bad(input logic [63:0] key);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(key[8*b +: 8]) % 2 == 0) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [63:0] fix_par(input logic [63:0] key);
    logic [63:0] k;
    k = key;
    for (int b = 0; b < 8; b++) k[8*b] = ~^k[8*b+1 +: 7];
    return k;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!o_ready && n < 40) begin
      step();
      n++;
    end
    check({nm, " ready"}, 64'(o_ready), 64'd1);
  endtask

  // Offer one block, check latency and result; consumes the result when i_ready is high.
  task automatic run_block(input string nm, input logic [63:0] ct, input logic [63:0] key,
                           input logic [63:0] exp_pt, input logic exp_err);
    int lat;
    wait_ready(nm);
    i_valid = 1'b1;
    i_ciphertext = ct;
    i_key = key;
    step();
    i_valid = 1'b0;
    i_ciphertext = {$urandom, $urandom};
    i_key = {$urandom, $urandom};
    wait_valid(lat);
    check({nm, " latency"}, 64'(lat), 64'd16);
    check({nm, " plaintext"}, o_plaintext, exp_pt);
    check({nm, " key_err"}, 64'(o_key_err), 64'(exp_err));
    if (i_ready) step();
  endtask

  typedef struct {
    string       nm;
    logic [63:0] ct;
    logic [63:0] key;
    logic [63:0] pt;
    logic        par_bad;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, seen;
    logic [63:0] pt, key, ct;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_ciphertext = '0; i_key = '0;
    for (int i = 0; i < 64; i++) fp_t.push_back(0);
    for (int i = 0; i < 64; i++) fp_t[ip_t[i] - 1] = i + 1;

    vecs[0] = '{"fips",      64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0};
    vecs[1] = '{"zero_key",  64'h8CA64DE9C1B123A7, 64'h0000000000000000, 64'h0000000000000000, 1'b1};
    vecs[2] = '{"kat_0e32",  64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0};
    vecs[3] = '{"fips_par",  64'h85E813540F0AB405, 64'h133457799BBCDFF0, 64'h0123456789ABCDEF, 1'b1};

    step(); step();
    check("reset o_ready", 64'(o_ready), 64'd1);
    check("reset o_valid", 64'(o_valid), 64'd0);
    check("reset o_plaintext", o_plaintext, 64'h0);
    check("reset o_key_err", 64'(o_key_err), 64'd0);
    i_rst = 1'b0;
    step();

    foreach (vecs[i]) run_block(vecs[i].nm, vecs[i].ct, vecs[i].key, vecs[i].pt, PAR_EN & vecs[i].par_bad);

    // Back-pressure: result held for 10 cycles while new offers are ignored.
    i_ready = 1'b0;
    run_block("bp", 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_ciphertext = {$urandom, $urandom};
      i_key = 64'h0;
      step();
      check("bp o_valid", 64'(o_valid), 64'd1);
      check("bp o_ready", 64'(o_ready), 64'd0);
      check("bp o_plaintext", o_plaintext, 64'h0123456789ABCDEF);
      check("bp o_key_err", 64'(o_key_err), 64'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    check("bp release o_valid", 64'(o_valid), 64'd0);
    check("bp release o_ready", 64'(o_ready), 64'd1);

    // Reset at step 7 discards the block in flight.
    wait_ready("rst");
    i_valid = 1'b1; i_ciphertext = 64'h85E813540F0AB405; i_key = 64'h0000000000000000;
    step();
    i_valid = 1'b0;
    repeat (7) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rst o_ready", 64'(o_ready), 64'd1);
    check("rst o_valid", 64'(o_valid), 64'd0);
    check("rst o_plaintext", o_plaintext, 64'h0);
    check("rst o_key_err", 64'(o_key_err), 64'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen += int'(o_valid);
    end
    check("rst no output", 64'(seen), 64'd0);
    run_block("post_rst", 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);

    // Back-to-back with i_valid held high: second acceptance one cycle after the first handshake.
    wait_ready("b2b");
    i_valid = 1'b1; i_ciphertext = 64'h0000000000000000; i_key = 64'h0E329232EA6D0D73;
    step();
    i_ciphertext = 64'h85E813540F0AB405; i_key = 64'h133457799BBCDFF1;
    wait_valid(lat);
    check("b2b first latency", 64'(lat), 64'd16);
    check("b2b first plaintext", o_plaintext, 64'h8787878787878787);
    step();
    check("b2b idle after handshake", 64'(o_ready), 64'd1);
    check("b2b o_valid one cycle", 64'(o_valid), 64'd0);
    step();
    check("b2b second accepted", 64'(o_ready), 64'd0);
    i_valid = 1'b0;
    wait_valid(lat);
    check("b2b second latency", 64'(lat), 64'd16);
    check("b2b second plaintext", o_plaintext, 64'h0123456789ABCDEF);
    step();

    // Random round-trips: encrypt in the model, decrypt in the DUT.
    for (int i = 0; i < 1000; i++) begin
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom};
      if (i % 2 == 0) key = fix_par(key);
      ct  = ref_des(pt, key, 1'b0);
      run_block($sformatf("rand%0d", i), ct, key, pt, PAR_EN & ref_par_bad(key));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
